// File: rtl/pulse_framer.sv
// Frames the interleaved sample stream per radar pulse: N samples followed by a
// 4-word trailer (sync, pulse count, timestamp), skipping pulses that cannot fit.
module pulse_framer #(
  parameter int                    data_width  = 16,
  parameter int                    count_width = 16,
  parameter int                    room_width  = 12,
  parameter logic [data_width-1:0] SYNC_WORD   = 16'h8000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   init,
  input  logic [data_width-1:0]  data_in,
  input  logic                   strobe_in,
  input  logic                   trigger,
  input  logic [count_width-1:0] n_samples,
  input  logic [room_width-1:0]  fifo_room,
  output logic [data_width-1:0]  fifo_data,
  output logic                   fifo_wr,
  output logic                   busy,
  output logic                   overrun,
  output logic [15:0]            skipped
);

  localparam int CMP_W = ((count_width > room_width) ? count_width : room_width) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLES,
    TRAILER
  } state_e;

  state_e                 state_q;
  logic                   trig_q;
  logic [31:0]            ts_q;
  logic [31:0]            ts_lat_q;
  logic [15:0]            pulse_cnt_q;
  logic [count_width-1:0] n_q;
  logic [count_width-1:0] cnt_q;
  logic [1:0]             phase_q;
  logic [data_width-1:0]  fifo_data_q;
  logic                   fifo_wr_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic [15:0]            skipped_q;

  logic                   clear;
  logic                   trig_edge;
  logic                   room_ok;
  logic [count_width-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    clear     = 1'b0;
    trig_edge = 1'b0;
    room_ok   = 1'b0;
    cnt_d     = cnt_q;
    clear     = reset | ~enable | init;
    trig_edge = trigger & ~trig_q;
    // Widened compare so n_samples + 4 cannot wrap against a narrower room value.
    room_ok   = (CMP_W'(fifo_room) >= (CMP_W'(n_samples) + CMP_W'(4)));
    cnt_d     = cnt_q + count_width'(1);
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      ts_q        <= '0;
      ts_lat_q    <= '0;
      pulse_cnt_q <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      fifo_data_q <= '0;
      fifo_wr_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      skipped_q   <= '0;
    end else begin
      ts_q      <= ts_q + 32'd1;
      trig_q    <= trigger;
      fifo_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (trig_edge && (n_samples != '0)) begin
            if (!room_ok) begin
              overrun_q <= 1'b1;
              if (skipped_q != 16'hFFFF) skipped_q <= skipped_q + 16'd1;
            end else begin
              n_q      <= n_samples;
              ts_lat_q <= ts_q;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= SAMPLES;
            end
          end
        end
        SAMPLES: begin
          busy_q <= 1'b1;
          if (strobe_in) begin
            fifo_data_q <= data_in;
            fifo_wr_q   <= 1'b1;
            cnt_q       <= cnt_d;
            if (cnt_d == n_q) begin
              state_q <= TRAILER;
              phase_q <= 2'd0;
            end
          end
        end
        TRAILER: begin
          // busy stays high through the final trailer write, which lands one cycle after IDLE is entered.
          busy_q    <= 1'b1;
          fifo_wr_q <= 1'b1;
          phase_q   <= phase_q + 2'd1;
          case (phase_q)
            2'd0: fifo_data_q <= SYNC_WORD;
            2'd1: fifo_data_q <= data_width'(pulse_cnt_q);
            2'd2: fifo_data_q <= data_width'(ts_lat_q[31:16]);
            2'd3: begin
              fifo_data_q <= data_width'(ts_lat_q[15:0]);
              pulse_cnt_q <= pulse_cnt_q + 16'd1;
              state_q     <= IDLE;
            end
            default: fifo_data_q <= fifo_data_q;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_data = fifo_data_q;
  assign fifo_wr   = fifo_wr_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign skipped   = skipped_q;

endmodule

// File: tb/tb_pulse_framer.sv
// Scoreboard bench for pulse_framer: the driver queues expected FIFO words,
// a negedge monitor pops and compares on every fifo_wr.
module tb_pulse_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        init;
  logic [15:0] data_in;
  logic        strobe_in;
  logic        trigger;
  logic [15:0] n_samples;
  logic [11:0] fifo_room;
  logic [15:0] fifo_data;
  logic        fifo_wr;
  logic        busy;
  logic        overrun;
  logic [15:0] skipped;

  always #5 clock = ~clock;

  pulse_framer dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .init     (init),
    .data_in  (data_in),
    .strobe_in(strobe_in),
    .trigger  (trigger),
    .n_samples(n_samples),
    .fifo_room(fifo_room),
    .fifo_data(fifo_data),
    .fifo_wr  (fifo_wr),
    .busy     (busy),
    .overrun  (overrun),
    .skipped  (skipped)
  );

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference timestamp: free-running, cleared like the DUT, loadable to mirror a forced value.
  logic [31:0] tb_ts;
  logic        ts_set = 1'b0;
  always @(posedge clock) begin
    if (reset || !enable || init) tb_ts <= '0;
    else if (ts_set)              tb_ts <= 32'hFFFF_FFFF;
    else                          tb_ts <= tb_ts + 32'd1;
  end

  always @(negedge clock) begin
    logic [15:0] exp_w;
    if (fifo_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %04h, expected no write at %0t", fifo_data, $time);
      end else begin
        exp_w = exp_q.pop_front();
        if (fifo_data !== exp_w) begin
          errors++;
          $display("FAIL fifo_word: got %04h, expected %04h at %0t", fifo_data, exp_w, $time);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] base, input int n, input logic [15:0] pcnt,
                            input logic [31:0] ts);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 16'(i));
    exp_q.push_back(16'h8000);
    exp_q.push_back(pcnt);
    exp_q.push_back(ts[31:16]);
    exp_q.push_back(ts[15:0]);
  endtask

  task automatic fire();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic send(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      data_in   = base + 16'(i);
      strobe_in = 1'b1;
      step();
      strobe_in = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    init      = 1'b0;
    data_in   = '0;
    strobe_in = 1'b0;
    trigger   = 1'b0;
    n_samples = '0;
    fifo_room = '0;

    // Reset state
    step();
    check("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_fifo_data", {16'd0, fifo_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_skipped", {16'd0, skipped}, 32'd0);
    step();
    reset = 1'b0;

    // Basic frame, edge seen with timestamp 10
    repeat (10) step();
    n_samples = 16'd3;
    fifo_room = 12'd100;
    push_frame(16'h0001, 3, 16'h0000, 32'd10);
    fire();
    check("busy_after_edge", {31'd0, busy}, 32'd1);
    send(16'h0001, 3);
    wait_idle("t1_idle");
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    check("t1_skipped", {16'd0, skipped}, 32'd0);

    // Edge during trailer ignored; edge on first IDLE cycle accepted
    do_reset();
    n_samples = 16'd2;
    push_frame(16'h0200, 2, 16'h0000, tb_ts);
    fire();
    send(16'h0200, 2);
    step();
    fire();
    step();
    step();
    push_frame(16'h0210, 2, 16'h0001, tb_ts);
    fire();
    check("busy_first_idle_edge", {31'd0, busy}, 32'd1);
    send(16'h0210, 2);
    wait_idle("t2_idle");
    check("t2_skipped", {16'd0, skipped}, 32'd0);
    check("t2_overrun", {31'd0, overrun}, 32'd0);

    // Strobes outside SAMPLES discarded; zero-length request ignored
    do_reset();
    send(16'h0300, 2);
    n_samples = 16'd2;
    push_frame(16'h0310, 2, 16'h0000, tb_ts);
    fire();
    send(16'h0310, 2);
    send(16'h0320, 3);
    wait_idle("t4_idle");
    n_samples = 16'd0;
    fire();
    step();
    check("t4_zero_busy", {31'd0, busy}, 32'd0);
    check("t4_zero_overrun", {31'd0, overrun}, 32'd0);
    check("t4_zero_skipped", {16'd0, skipped}, 32'd0);

    // Room boundary: 13 words short by one, 14 fits exactly
    do_reset();
    n_samples = 16'd10;
    fifo_room = 12'd13;
    fire();
    send(16'h0400, 3);
    check("t3_skip_overrun", {31'd0, overrun}, 32'd1);
    check("t3_skip_count", {16'd0, skipped}, 32'd1);
    check("t3_skip_busy", {31'd0, busy}, 32'd0);
    fifo_room = 12'd14;
    push_frame(16'h0410, 10, 16'h0000, tb_ts);
    fire();
    send(16'h0410, 10);
    wait_idle("t3_idle");
    check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("t3_skipped_hold", {16'd0, skipped}, 32'd1);

    // init mid-frame clears everything, no trailer for the aborted frame
    n_samples = 16'd5;
    fifo_room = 12'd100;
    exp_q.push_back(16'h0500);
    exp_q.push_back(16'h0501);
    fire();
    send(16'h0500, 2);
    init = 1'b1;
    step();
    check("t5_init_busy", {31'd0, busy}, 32'd0);
    check("t5_init_overrun", {31'd0, overrun}, 32'd0);
    check("t5_init_skipped", {16'd0, skipped}, 32'd0);
    step();
    init = 1'b0;
    repeat (4) step();
    n_samples = 16'd1;
    push_frame(16'h0510, 1, 16'h0000, 32'd4);
    fire();
    send(16'h0510, 1);
    wait_idle("t5_idle");

    // Timestamp wrap
    force dut.ts_q = 32'hFFFF_FFFE;
    ts_set = 1'b1;
    #1;
    release dut.ts_q;
    step();
    ts_set = 1'b0;
    push_frame(16'h0600, 1, 16'h0001, 32'hFFFF_FFFF);
    fire();
    send(16'h0600, 1);
    wait_idle("t6_idle_a");
    check("t6_ts_wrapped", {31'd0, (tb_ts < 32'd100)}, 32'd1);
    push_frame(16'h0610, 1, 16'h0002, tb_ts);
    fire();
    send(16'h0610, 1);
    wait_idle("t6_idle_b");

    repeat (3) step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
